// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared constants and helpers for the openMips pipeline control block.
//   - stall masks (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB)
//   - exception codes as seen on excepttype_i
//   - exception FSM state encoding
//   - stall priority and redirect-target decode functions
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000A;
    localparam logic [31:0] EXC_OV      = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_t;

    // The deepest stage asking for a stall wins: freezing MEM also freezes
    // everything in front of it.
    function automatic logic [5:0] stall_mask(input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
        logic [5:0] mask;
        mask = STALL_NONE;
        if (req_mem) begin
            mask = STALL_MEM;
        end else if (req_ex) begin
            mask = STALL_EX;
        end else if (req_id) begin
            mask = STALL_ID;
        end
        return mask;
    endfunction

    // Only interrupts and eret have their own targets; every other code,
    // including an unexpected zero, goes to the general vector.
    function automatic logic [31:0] redirect_target(input logic [31:0] code,
                                                    input logic [31:0] epc,
                                                    input logic [31:0] vec_int,
                                                    input logic [31:0] vec_gen);
        logic [31:0] target;
        case (code)
            EXC_INT:     target = vec_int;
            EXC_ERET:    target = epc;
            EXC_SYSCALL,
            EXC_INVALID,
            EXC_OV,
            EXC_TRAP:    target = vec_gen;
            default:     target = vec_gen;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at MAX instead of wrapping. clr wins over inc.
//   Ports:
//     clk   in  1  rising-edge clock
//     rst_n in  1  asynchronous active-low reset (count -> 0)
//     inc   in  1  count up by one unless already at MAX
//     clr   in  1  synchronous clear
//     count out W  current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int             W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline control for the five-stage openMips core: combinational stall
//   vector, registered one-cycle flush/redirect on exceptions and eret,
//   saturating per-source stall counters, flush counter and a sticky stall
//   watchdog.
//   Ports:
//     clk, rst_n          clock / asynchronous active-low reset
//     stallreq_from_id    ID load-use bubble request
//     stallreq_from_ex    EX busy request
//     stallreq_from_mem   MEM bus-wait request
//     exc_valid           MEM commits an exception this cycle
//     excepttype_i[31:0]  exception code, qualified by exc_valid
//     cp0_epc_i[31:0]     EPC used as the eret target
//     stall[5:0]          per-stage hold (bit0 PC .. bit5 WB)
//     flush               one-cycle clear of all pipeline registers
//     new_pc[31:0]        redirect target, valid while flush=1, then held
//     stall_timeout       sticky watchdog flag
//     cnt_stall_id/ex/mem winning-source stall cycles (saturating)
//     cnt_flush           flushes issued (saturating)
//   Handshake: there is no back-pressure. exc_valid is a single-cycle
//   qualifier sampled on the rising edge while the FSM is IDLE; the flush it
//   causes is visible for exactly the following cycle.
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int          WDOG_MAX    = 1023,
    parameter logic [31:0] EXC_VEC_INT = 32'h0000_0020,
    parameter logic [31:0] EXC_VEC_GEN = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic             exc_valid,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] cnt_stall_id,
    output logic [CNT_W-1:0] cnt_stall_ex,
    output logic [CNT_W-1:0] cnt_stall_mem,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int             RUN_W   = $clog2(WDOG_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_MAX);

    exc_state_t       state_q;
    exc_state_t       state_d;
    logic             take_exc;
    logic [RUN_W-1:0] run_cnt;
    logic             run_at_max;
    logic             timeout_q;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        take_exc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    take_exc = 1'b1;
                    state_d  = ST_FLUSH;
                end
            end
            // The instruction presenting exc_valid here is being discarded.
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign flush = (state_q == ST_FLUSH);

    // Target is captured on the same edge that enters FLUSH and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_pc <= 32'h0;
        end else if (take_exc) begin
            new_pc <= redirect_target(excepttype_i, cp0_epc_i,
                                      EXC_VEC_INT, EXC_VEC_GEN);
        end
    end

    // ---------------------------------------------------------------- stall
    // Gated by rst_n so the pipeline registers see no hold while in reset.
    always_comb begin
        stall = STALL_NONE;
        if (rst_n && !flush) begin
            stall = stall_mask(stallreq_from_id, stallreq_from_ex,
                               stallreq_from_mem);
        end
    end

    // ------------------------------------------------------------- counters
    // stall already encodes the winner and is zero during flush.
    sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_cnt_id (
        .clk(clk), .rst_n(rst_n), .inc(stall == STALL_ID), .clr(1'b0),
        .count(cnt_stall_id)
    );

    sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_cnt_ex (
        .clk(clk), .rst_n(rst_n), .inc(stall == STALL_EX), .clr(1'b0),
        .count(cnt_stall_ex)
    );

    sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_cnt_mem (
        .clk(clk), .rst_n(rst_n), .inc(stall == STALL_MEM), .clr(1'b0),
        .count(cnt_stall_mem)
    );

    sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_cnt_flush (
        .clk(clk), .rst_n(rst_n), .inc(take_exc), .clr(1'b0),
        .count(cnt_flush)
    );

    // ------------------------------------------------------------- watchdog
    sat_counter #(.W(RUN_W), .MAX(RUN_MAX)) u_run (
        .clk(clk), .rst_n(rst_n), .inc(stall[0]), .clr(!stall[0]),
        .count(run_cnt)
    );

    assign run_at_max = (run_cnt == RUN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (run_at_max) begin
            timeout_q <= 1'b1;
        end
    end

    // Flag rises in the same cycle the run counter lands on the limit.
    assign stall_timeout = timeout_q | run_at_max;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl with CNT_W=4 and WDOG_MAX=8. Redirect targets
//   are queued when an exception is driven; a monitor pops one entry for each
//   flush cycle the DUT presents. Stall vectors and counters are checked
//   directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic             stallreq_from_mem;
    logic             exc_valid;
    logic [31:0]      excepttype_i;
    logic [31:0]      cp0_epc_i;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
    logic [CNT_W-1:0] cnt_stall_id;
    logic [CNT_W-1:0] cnt_stall_ex;
    logic [CNT_W-1:0] cnt_stall_mem;
    logic [CNT_W-1:0] cnt_flush;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_q[$];

    pipe_ctrl #(
        .CNT_W(CNT_W),
        .WDOG_MAX(8),
        .EXC_VEC_INT(32'h0000_0020),
        .EXC_VEC_GEN(32'h0000_0040)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stallreq_from_id(stallreq_from_id),
        .stallreq_from_ex(stallreq_from_ex),
        .stallreq_from_mem(stallreq_from_mem),
        .exc_valid(exc_valid),
        .excepttype_i(excepttype_i),
        .cp0_epc_i(cp0_epc_i),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .stall_timeout(stall_timeout),
        .cnt_stall_id(cnt_stall_id),
        .cnt_stall_ex(cnt_stall_ex),
        .cnt_stall_mem(cnt_stall_mem),
        .cnt_flush(cnt_flush)
    );

    // ------------------------------------------------------ clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------ helpers
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and checks run 1ns after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input logic id, input logic ex, input logic mem);
        stallreq_from_id  = id;
        stallreq_from_ex  = ex;
        stallreq_from_mem = mem;
        #1;
    endtask

    task automatic raise_exc(input logic [31:0] code, input logic [31:0] target);
        exc_valid    = 1'b1;
        excepttype_i = code;
        exp_q.push_back(target);
    endtask

    task automatic check_counters(input string tag, input int id, input int ex,
                                  input int mem, input int fl);
        check({tag, ".cnt_id"},    32'(cnt_stall_id),  32'(id));
        check({tag, ".cnt_ex"},    32'(cnt_stall_ex),  32'(ex));
        check({tag, ".cnt_mem"},   32'(cnt_stall_mem), 32'(mem));
        check({tag, ".cnt_flush"}, 32'(cnt_flush),     32'(fl));
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (rst_n && flush) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL mon.unexpected_flush: got new_pc %h expected no flush", new_pc);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = exp_q.pop_front();
                if (new_pc !== exp_pc) begin
                    n_fails++;
                    $display("FAIL mon.new_pc: got %h expected %h", new_pc, exp_pc);
                end
            end
            n_checks++;
            if (stall !== 6'b000000) begin
                n_fails++;
                $display("FAIL mon.stall_in_flush: got %b expected 000000", stall);
            end
        end
    end

    // ----------------------------------------------------------- stimulus
    initial begin
        rst_n             = 1'b0;
        stallreq_from_id  = 1'b0;
        stallreq_from_ex  = 1'b0;
        stallreq_from_mem = 1'b1;
        exc_valid         = 1'b0;
        excepttype_i      = 32'h0;
        cp0_epc_i         = 32'h0;
        #2;
        // Reset state, with a request pending that must not reach stall.
        check("rst.stall", 32'(stall), 32'h0);
        check("rst.flush", 32'(flush), 32'h0);
        check("rst.new_pc", new_pc, 32'h0);
        check("rst.timeout", 32'(stall_timeout), 32'h0);
        check_counters("rst", 0, 0, 0, 0);
        set_req(1'b0, 1'b0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step();

        // Priority and per-source counting.
        set_req(1'b1, 1'b0, 1'b0);
        check("id.stall", 32'(stall), 32'b000111);
        step();
        check("id.cnt", 32'(cnt_stall_id), 32'd1);
        set_req(1'b1, 1'b1, 1'b1);
        check("all.stall", 32'(stall), 32'b011111);
        step();
        check_counters("all", 1, 0, 1, 0);
        set_req(1'b1, 1'b1, 1'b0);
        check("ex_id.stall", 32'(stall), 32'b001111);
        step();
        set_req(1'b0, 1'b0, 1'b0);
        check("none.stall", 32'(stall), 32'h0);
        check_counters("ex", 1, 1, 1, 0);

        // eret redirect to EPC.
        cp0_epc_i = 32'h0000_1234;
        raise_exc(32'hE, 32'h0000_1234);
        step();
        exc_valid = 1'b0;
        check("eret.flush", 32'(flush), 32'h1);
        step();
        check("eret.flush_drop", 32'(flush), 32'h0);
        check("eret.new_pc_hold", new_pc, 32'h0000_1234);
        check("eret.cnt_flush", 32'(cnt_flush), 32'd1);

        // Interrupt alongside an EX stall: stall this cycle, flush next.
        set_req(1'b0, 1'b1, 1'b0);
        raise_exc(32'h1, 32'h0000_0020);
        #1;
        check("int.stall_same", 32'(stall), 32'b001111);
        step();
        exc_valid = 1'b0;
        check("int.flush", 32'(flush), 32'h1);
        check("int.stall_flush", 32'(stall), 32'h0);
        set_req(1'b0, 1'b0, 1'b0);
        step();
        // One EX cycle counted before the flush, none during it.
        check_counters("int", 1, 2, 1, 2);

        // exc_valid held three cycles: the sample taken in FLUSH is dropped.
        raise_exc(32'hC, 32'h0000_0040);
        exp_q.push_back(32'h0000_0040);
        step();
        check("hold.flush0", 32'(flush), 32'h1);
        step();
        check("hold.flush1", 32'(flush), 32'h0);
        step();
        exc_valid = 1'b0;
        check("hold.flush2", 32'(flush), 32'h1);
        step();
        check("hold.flush3", 32'(flush), 32'h0);
        check("hold.cnt_flush", 32'(cnt_flush), 32'd4);

        // Zero code with exc_valid is a general exception.
        raise_exc(32'h0, 32'h0000_0040);
        step();
        exc_valid = 1'b0;
        check("zero.new_pc", new_pc, 32'h0000_0040);
        step();

        // Watchdog: 7-cycle stall leaves the flag clear.
        set_req(1'b0, 1'b0, 1'b1);
        step(7);
        check("wd7.timeout", 32'(stall_timeout), 32'h0);
        set_req(1'b0, 1'b0, 1'b0);
        step();
        check("wd7.after", 32'(stall_timeout), 32'h0);

        // 8-cycle stall sets it, and it sticks; mem counter saturates (1+7+8).
        set_req(1'b0, 1'b0, 1'b1);
        step(7);
        check("wd8.before", 32'(stall_timeout), 32'h0);
        step();
        check("wd8.timeout", 32'(stall_timeout), 32'h1);
        set_req(1'b0, 1'b0, 1'b0);
        step(2);
        check("wd8.sticky", 32'(stall_timeout), 32'h1);
        check("sat.cnt_mem", 32'(cnt_stall_mem), 32'd15);

        // Reset in the middle of a flush.
        raise_exc(32'h8, 32'h0000_0040);
        step();
        exc_valid = 1'b0;
        check("rstf.flush", 32'(flush), 32'h1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstf.flush_drop", 32'(flush), 32'h0);
        check("rstf.new_pc", new_pc, 32'h0);
        check("rstf.timeout", 32'(stall_timeout), 32'h0);
        check_counters("rstf", 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step(2);
        check("rstf.no_redirect", 32'(flush), 32'h0);

        // Saturation of the ID counter at 4 bits.
        set_req(1'b1, 1'b0, 1'b0);
        step(20);
        set_req(1'b0, 1'b0, 1'b0);
        check("sat.cnt_id", 32'(cnt_stall_id), 32'd15);

        step(2);
        check("sb.drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
